// File: rtl/core_pkg.sv
// Types and constants shared by the RV32I front end.
package core_pkg;

  localparam logic [31:0] NOP_INST             = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  localparam int unsigned ENTRY_W = $bits(fetch_entry_t);

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of {pc, inst} entries with a registered-pointer head
// and a flush that empties it in one cycle.
module fetch_fifo
  import core_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         flush_i,
  input  logic                         push_i,
  input  logic [ENTRY_W-1:0]           data_i,
  input  logic                         pop_i,
  output logic [ENTRY_W-1:0]           data_o,
  output logic                         empty_o,
  output logic                         full_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == FULL_CNT);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  // Flush overrides both ports so a same-cycle push or pop cannot leak through.
  assign do_push = push_i && !full_o && !flush_i;
  assign do_pop  = pop_i && !empty_o && !flush_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
      end
      if (do_push && !do_pop) begin
        count_d = count_q + 1'b1;
      end else if (!do_push && do_pop) begin
        count_d = count_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  a_no_push_when_full: assert property (@(posedge clk_i) disable iff (rst_i)
    !(push_i && full_o && !flush_i));

endmodule

// File: rtl/fetch_unit.sv
// RV32I instruction fetch: owns the PC, issues credit-limited word reads,
// buffers returned words with their PCs and handles redirects from execute.
module fetch_unit
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
  parameter int unsigned FIFO_DEPTH   = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] inst_o,
  output logic [31:0] pc_o,
  output logic        valid_o,
  input  logic        ready_i
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W:0] CREDITS = (CNT_W + 1)'(FIFO_DEPTH);

  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [31:0]      last_pc_q;
  logic [CNT_W-1:0] outstanding_q, outstanding_d;
  logic [CNT_W-1:0] discard_q, discard_d;

  logic             credit_ok, grant, rsp_ok, rsp_keep;
  logic             buf_push, buf_pop, buf_empty, buf_full;
  logic [CNT_W-1:0] buf_count;
  fetch_entry_t     buf_in, buf_head;
  logic             pcq_push, pcq_pop, pcq_empty, pcq_full;
  logic [CNT_W-1:0] pcq_count;
  fetch_entry_t     pcq_in, pcq_head;

  // Every word in flight already owns a buffer slot, so the buffer cannot overflow.
  assign credit_ok   = ({1'b0, outstanding_q} + {1'b0, buf_count}) < CREDITS;
  assign imem_req_o  = !rst_i && !redirect_i && credit_ok;
  assign imem_addr_o = fetch_pc_q;
  assign grant       = imem_req_o && imem_gnt_i;

  assign rsp_ok   = imem_rvalid_i && (outstanding_q != '0);
  assign rsp_keep = rsp_ok && (discard_q == '0) && !redirect_i;

  assign pcq_push = grant;
  assign pcq_pop  = rsp_ok;
  assign pcq_in   = '{pc: fetch_pc_q, inst: NOP_INST};

  assign buf_push = rsp_keep;
  assign buf_pop  = valid_o && ready_i && !redirect_i;
  assign buf_in   = '{pc: pcq_head.pc, inst: imem_rdata_i};

  assign valid_o = !buf_empty;
  assign inst_o  = buf_empty ? NOP_INST : buf_head.inst;
  assign pc_o    = buf_empty ? last_pc_q : buf_head.pc;

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_inst_buf (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (redirect_i),
    .push_i  (buf_push),
    .data_i  (buf_in),
    .pop_i   (buf_pop),
    .data_o  (buf_head),
    .empty_o (buf_empty),
    .full_o  (buf_full),
    .count_o (buf_count)
  );

  // The PC queue is never flushed by a redirect: stale responses still pop it.
  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_pc_queue (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (1'b0),
    .push_i  (pcq_push),
    .data_i  (pcq_in),
    .pop_i   (pcq_pop),
    .data_o  (pcq_head),
    .empty_o (pcq_empty),
    .full_o  (pcq_full),
    .count_o (pcq_count)
  );

  logic unused_ok;
  assign unused_ok = ^{buf_full, pcq_empty, pcq_full, pcq_count, pcq_head.inst};

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (redirect_i) begin
      fetch_pc_d = align_word(redirect_pc_i);
    end else if (grant) begin
      fetch_pc_d = fetch_pc_q + 32'd4;
    end
  end

  always_comb begin
    outstanding_d = outstanding_q;
    if (grant && !rsp_ok) begin
      outstanding_d = outstanding_q + 1'b1;
    end else if (!grant && rsp_ok) begin
      outstanding_d = outstanding_q - 1'b1;
    end
  end

  // A response landing in the redirect cycle is already dropped, so it is not re-counted.
  always_comb begin
    discard_d = discard_q;
    if (redirect_i) begin
      discard_d = outstanding_q - CNT_W'(rsp_ok);
    end else if (rsp_ok && (discard_q != '0)) begin
      discard_d = discard_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fetch_pc_q    <= RESET_VECTOR;
      last_pc_q     <= RESET_VECTOR;
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      if (!buf_empty) begin
        last_pc_q <= buf_head.pc;
      end
    end
  end

  a_no_orphan_rvalid: assert property (@(posedge clk_i) disable iff (rst_i)
    imem_rvalid_i |-> (outstanding_q != '0));

  a_discard_bounded: assert property (@(posedge clk_i) disable iff (rst_i)
    discard_q <= outstanding_q);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a memory responder issues grants and records the
// expected {pc, inst} stream, and a separate monitor checks every instruction popped.
module tb_fetch_unit;
  import core_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic [31:0] inst_o;
  logic [31:0] pc_o;
  logic        valid_o;
  logic        ready_i;

  int vectors     = 0;
  int miscompares = 0;

  logic gnt_en = 1'b0;
  logic hold   = 1'b0;
  logic [31:0]  pend_q[$];
  logic [31:0]  grant_log[$];
  fetch_entry_t exp_q[$];

  fetch_unit dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .inst_o        (inst_o),
    .pc_o          (pc_o),
    .valid_o       (valid_o),
    .ready_i       (ready_i)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hABCD_0000;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %08h, want %08h", name, act, exp);
    end else begin
      $display("ok   %s: %08h", name, act);
    end
  endtask

  task automatic check_grant(input string name, input int idx, input logic [31:0] exp);
    if (idx >= grant_log.size()) begin
      vectors++;
      miscompares++;
      $display("FAIL %s: got only %0d grants, want grant #%0d at %08h", name, grant_log.size(), idx, exp);
    end else begin
      check(name, grant_log[idx], exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk_i);
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic wait_valid(input string name, output bit found);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      cyc();
      settle();
      if (valid_o) found = 1'b1;
    end
    if (!found) begin
      vectors++;
      miscompares++;
      $display("FAIL %s: got no valid_o within 20 cycles, want valid_o=1", name);
    end
  endtask

  // Memory: grants when gnt_en, answers in order one cycle later unless held.
  initial begin : responder
    logic [31:0] a;
    imem_gnt_i    = 1'b0;
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = '0;
    forever begin
      @(negedge clk_i);
      #1;
      imem_gnt_i = gnt_en;
      if (rst_i) begin
        pend_q.delete();
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = '0;
      end else if (!hold && pend_q.size() > 0) begin
        a = pend_q.pop_front();
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = mem_word(a);
      end else begin
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = '0;
      end
      #1;
      if (imem_req_o && imem_gnt_i) begin
        pend_q.push_back(imem_addr_o);
        grant_log.push_back(imem_addr_o);
        exp_q.push_back('{pc: imem_addr_o, inst: mem_word(imem_addr_o)});
        $display("grant addr=%08h", imem_addr_o);
      end
    end
  end

  initial begin : monitor
    fetch_entry_t e;
    forever begin
      @(negedge clk_i);
      #3;
      if (!rst_i && !redirect_i && valid_o && ready_i) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL pop_unexpected: got pc %08h inst %08h, want no instruction", pc_o, inst_o);
        end else begin
          e = exp_q.pop_front();
          check("pop_pc", pc_o, e.pc);
          check("pop_inst", inst_o, e.inst);
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got timeout, want $finish");
    $fatal(1, "bench timeout");
  end

  initial begin : stim
    bit found;
    rst_i         = 1'b1;
    redirect_i    = 1'b0;
    redirect_pc_i = '0;
    ready_i       = 1'b1;
    gnt_en        = 1'b1;
    hold          = 1'b0;

    repeat (2) cyc();
    settle();
    check("rst_req",   32'(imem_req_o), 32'd0);
    check("rst_valid", 32'(valid_o), 32'd0);
    check("rst_inst",  inst_o, NOP_INST);
    check("rst_pc",    pc_o, 32'h0);
    check("rst_addr",  imem_addr_o, 32'h0);

    // Straight-line fetch from the reset vector
    cyc(); rst_i = 1'b0; settle();
    check("t1_c0_req",   32'(imem_req_o), 32'd1);
    check("t1_c0_addr",  imem_addr_o, 32'h0);
    check("t1_c0_valid", 32'(valid_o), 32'd0);
    cyc(); settle();
    check("t1_c1_addr",  imem_addr_o, 32'h4);
    check("t1_c1_valid", 32'(valid_o), 32'd0);
    cyc(); settle();
    check("t1_c2_valid", 32'(valid_o), 32'd1);
    check("t1_c2_pc",    pc_o, 32'h0);
    check("t1_c2_inst",  inst_o, 32'hABCD_0000);
    repeat (8) cyc();
    settle();
    check_grant("t1_grant0", 0, 32'h0);
    check_grant("t1_grant1", 1, 32'h4);
    check_grant("t1_grant2", 2, 32'h8);

    // Decoder stall: buffer fills, requests stop, head holds
    cyc(); rst_i = 1'b1; ready_i = 1'b0; exp_q.delete(); grant_log.delete();
    cyc();
    cyc(); rst_i = 1'b0;
    repeat (5) cyc();
    settle();
    check("t2_req",  32'(imem_req_o), 32'd0);
    check("t2_valid", 32'(valid_o), 32'd1);
    check("t2_pc",   pc_o, 32'h0);
    check("t2_inst", inst_o, 32'hABCD_0000);
    repeat (3) cyc();
    settle();
    check("t2_hold_pc",   pc_o, 32'h0);
    check("t2_hold_inst", inst_o, 32'hABCD_0000);
    check("t2_hold_req",  32'(imem_req_o), 32'd0);
    cyc(); ready_i = 1'b1; settle();

    // Memory stalls grants: request and address must hold
    cyc(); gnt_en = 1'b0; settle();
    check("t2_resume_req",  32'(imem_req_o), 32'd1);
    check("t2_resume_addr", imem_addr_o, 32'h8);
    check("t2_next_pc",     pc_o, 32'h4);
    for (int i = 0; i < 4; i++) begin
      cyc(); settle();
      check("t3_req",  32'(imem_req_o), 32'd1);
      check("t3_addr", imem_addr_o, 32'h8);
    end

    // Redirect with two responses still in flight
    cyc(); gnt_en = 1'b1; hold = 1'b1;
    cyc();
    cyc(); settle();
    check("t4_req_blocked", 32'(imem_req_o), 32'd0);
    check("t4_valid_empty", 32'(valid_o), 32'd0);
    cyc(); redirect_i = 1'b1; redirect_pc_i = 32'h100; exp_q.delete(); settle();
    check("t4_redir_req", 32'(imem_req_o), 32'd0);
    cyc(); redirect_i = 1'b0; hold = 1'b0; settle();
    check("t4_addr", imem_addr_o, 32'h100);
    wait_valid("t4_wait", found);
    if (found) begin
      check("t4_pc",   pc_o, 32'h100);
      check("t4_inst", inst_o, 32'hABCD_0100);
    end

    // Misaligned target, then a back-to-back redirect to the top of memory
    cyc(); redirect_i = 1'b1; redirect_pc_i = 32'h103; exp_q.delete();
    cyc(); redirect_pc_i = 32'hFFFF_FFFC; exp_q.delete(); grant_log.delete(); settle();
    check("t5_align_addr", imem_addr_o, 32'h100);
    check("t5_b2b_req",    32'(imem_req_o), 32'd0);
    cyc(); redirect_i = 1'b0; settle();
    check("t5_top_addr", imem_addr_o, 32'hFFFF_FFFC);
    wait_valid("t5_wait_top", found);
    if (found) begin
      check("t5_top_pc",   pc_o, 32'hFFFF_FFFC);
      check("t5_top_inst", inst_o, 32'h5432_FFFC);
    end
    wait_valid("t5_wait_wrap", found);
    if (found) begin
      check("t5_wrap_pc",   pc_o, 32'h0);
      check("t5_wrap_inst", inst_o, 32'hABCD_0000);
    end
    check_grant("t5_grant0", 0, 32'hFFFF_FFFC);
    check_grant("t5_grant1", 1, 32'h0);

    // Reset with a full buffer drops everything
    cyc(); ready_i = 1'b0;
    repeat (8) cyc();
    settle();
    check("t6_full_valid", 32'(valid_o), 32'd1);
    check("t6_full_req",   32'(imem_req_o), 32'd0);
    cyc(); rst_i = 1'b1; exp_q.delete(); grant_log.delete(); settle();
    check("t6_rst_req", 32'(imem_req_o), 32'd0);
    cyc(); rst_i = 1'b0; ready_i = 1'b1; settle();
    check("t6_valid", 32'(valid_o), 32'd0);
    check("t6_inst",  inst_o, NOP_INST);
    check("t6_addr",  imem_addr_o, 32'h0);
    check("t6_pc",    pc_o, 32'h0);
    check("t6_req",   32'(imem_req_o), 32'd1);
    repeat (6) cyc();
    settle();
    check_grant("t6_first_fetch", 0, 32'h0);
    cyc(); gnt_en = 1'b0;
    repeat (8) cyc();
    settle();
    check("t6_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
